pll_lock_supervisor: RTL and testbench

Reset-and-lock sequencer for the core's main video/audio PLL. Drives the PLL reset input, synchronizes its asynchronous `locked` flag, retries on lock timeout, and holds the core-wide reset until the lock has been stable for a programmable window. It sits between the bridge clock domain and the PLL wrapper, and is the single source of `core_reset_n` for all PLL-derived domains.

---
 rtl/pll_sup_pkg.sv | 29 ++
 rtl/pll_sup_sync.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Optional feature macro: PLL_SUP_STATUS_EN (enables the relock_count status counter).
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 74250;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 7;
    localparam int DEF_SYNC_STAGES         = 2;

    localparam int RETRY_CNT_W  = 4;
    localparam int RELOCK_CNT_W = 16;

    // Saturating increment for the lock-loss event counter.
    function automatic logic [RELOCK_CNT_W-1:0] relock_sat_inc(
        input logic [RELOCK_CNT_W-1:0] value
    );
        return (&value) ? value : value + RELOCK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Generic N-stage single-bit synchronizer, async active-low reset to 0.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Reset-and-lock sequencer for the main PLL: pulses the PLL reset, waits for a
// stable synchronized lock, retries on timeout and owns core_reset_n.
// Optional feature macro: PLL_SUP_STATUS_EN adds the relock_count port/counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
    input  logic                    clk_74a,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic                    relock_req,
    output logic                    pll_rst,
    output logic                    core_reset_n,
    output logic                    ready,
    output logic                    fault,
    output logic [RETRY_CNT_W-1:0]  retry_count
`ifdef PLL_SUP_STATUS_EN
    ,
    output logic [RELOCK_CNT_W-1:0] relock_count
`endif
);

    localparam int RST_CNT_W = $clog2(RST_PULSE_CYCLES + 1);
    localparam int TO_CNT_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int STB_CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);

    pll_sup_state_t         state;
    pll_sup_state_t         next_state;
    logic                   lock_sync;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic [RST_CNT_W-1:0]   rst_cnt_d;
    logic [TO_CNT_W-1:0]    to_cnt;
    logic [TO_CNT_W-1:0]    to_cnt_d;
    logic [STB_CNT_W-1:0]   stb_cnt;
    logic [STB_CNT_W-1:0]   stb_cnt_d;
    logic [RETRY_CNT_W-1:0] retry_d;
    logic [RETRY_CNT_W-1:0] retry_inc;
`ifdef PLL_SUP_STATUS_EN
    logic [RELOCK_CNT_W-1:0] relock_d;
`endif

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk_74a),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lock_sync)
    );

    assign retry_inc = retry_count + RETRY_CNT_W'(1);

    // Next-state and counter logic; counters default to 0 so every state entry clears them.
    always_comb begin
        next_state = state;
        rst_cnt_d  = '0;
        to_cnt_d   = '0;
        stb_cnt_d  = '0;
        retry_d    = retry_count;
`ifdef PLL_SUP_STATUS_EN
        relock_d   = relock_count;
`endif
        case (state)
            ST_RESET_PLL: begin
                if (rst_cnt == RST_CNT_W'(RST_PULSE_CYCLES - 1)) begin
                    next_state = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt + RST_CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    next_state = ST_STABLE;
                end else if (to_cnt == TO_CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_CNT_W'(MAX_RETRIES)) begin
                        next_state = ST_FAULT;
                    end else begin
                        next_state = ST_RESET_PLL;
                    end
                end else begin
                    to_cnt_d = to_cnt + TO_CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_sync) begin
                    next_state = ST_WAIT_LOCK;
                end else if (stb_cnt == STB_CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    next_state = ST_RUN;
                    retry_d    = '0;
                end else begin
                    stb_cnt_d = stb_cnt + STB_CNT_W'(1);
                end
            end
            ST_RUN: begin
                // An explicit relock request takes priority over a simultaneous lock loss.
                if (relock_req) begin
                    next_state = ST_RESET_PLL;
                    retry_d    = '0;
                end else if (!lock_sync) begin
                    next_state = ST_RESET_PLL;
`ifdef PLL_SUP_STATUS_EN
                    relock_d   = relock_sat_inc(relock_count);
`endif
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    next_state = ST_RESET_PLL;
                    retry_d    = '0;
                end
            end
            default: begin
                next_state = ST_RESET_PLL;
            end
        endcase
    end

    // State, counters and outputs; outputs are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RESET_PLL;
            rst_cnt      <= '0;
            to_cnt       <= '0;
            stb_cnt      <= '0;
            retry_count  <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= next_state;
            rst_cnt      <= rst_cnt_d;
            to_cnt       <= to_cnt_d;
            stb_cnt      <= stb_cnt_d;
            retry_count  <= retry_d;
            pll_rst      <= (next_state == ST_RESET_PLL) || (next_state == ST_FAULT);
            core_reset_n <= (next_state == ST_RUN);
            ready        <= (next_state == ST_RUN);
            fault        <= (next_state == ST_FAULT);
        end
    end

`ifdef PLL_SUP_STATUS_EN
    // Saturating count of lock-loss events observed while running.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            relock_count <= '0;
        end else begin
            relock_count <= relock_d;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural reference model.
// Honours PLL_SUP_STATUS_EN for the relock_count checks.
module tb_pll_lock_supervisor;

    localparam int RST  = 4;
    localparam int TO   = 32;
    localparam int STB  = 8;
    localparam int MAXR = 2;
    localparam int SYN  = 2;

    localparam int P_RESET  = 10;
    localparam int P_WAIT   = 11;
    localparam int P_STABLE = 12;
    localparam int P_RUN    = 13;
    localparam int P_FAULT  = 14;

    typedef struct {
        bit         lock;
        bit         relock;
        int         cycles;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic        clk_74a;
    logic        reset_n;
    logic        pll_locked;
    logic        relock_req;
    logic        pll_rst;
    logic        core_reset_n;
    logic        ready;
    logic        fault;
    logic [3:0]  retry_count;
`ifdef PLL_SUP_STATUS_EN
    logic [15:0] relock_count;
`endif

    int tests;
    int fails;

    // reference model state
    int     m_ph;
    longint m_cyc;
    longint m_entry;
    int     m_retry;
    int     m_relock;
    bit     m_q[$];

    vec_t vecs[13];

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (RST),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (STB),
        .MAX_RETRIES         (MAXR),
        .SYNC_STAGES         (SYN)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .ready        (ready),
        .fault        (fault),
        .retry_count  (retry_count)
`ifdef PLL_SUP_STATUS_EN
        ,
        .relock_count (relock_count)
`endif
    );

    initial clk_74a = 1'b0;
    always #5 clk_74a = ~clk_74a;

    function automatic logic [7:0] pk(input bit pr, input bit cr, input bit rd,
                                      input bit ft, input int rc);
        return {pr, cr, rd, ft, 4'(rc)};
    endfunction

    function automatic void model_reset();
        m_ph     = P_RESET;
        m_cyc    = 0;
        m_entry  = 0;
        m_retry  = 0;
        m_relock = 0;
        m_q      = {};
        for (int i = 0; i < SYN; i++) m_q.push_back(1'b0);
    endfunction

    // One clock edge of the specified behaviour: dwell time since phase entry decides transitions.
    function automatic void model_step(input bit lock, input bit req);
        bit     synced;
        longint dwell;
        int     nxt;
        synced = m_q.pop_front();
        m_q.push_back(lock);
        dwell = m_cyc - m_entry + 1;
        nxt   = m_ph;
        case (m_ph)
            P_RESET:  if (dwell >= RST) nxt = P_WAIT;
            P_WAIT: begin
                if (synced) nxt = P_STABLE;
                else if (dwell >= TO) begin
                    m_retry++;
                    nxt = (m_retry == MAXR) ? P_FAULT : P_RESET;
                end
            end
            P_STABLE: begin
                if (!synced) nxt = P_WAIT;
                else if (dwell >= STB) begin
                    nxt = P_RUN;
                    m_retry = 0;
                end
            end
            P_RUN: begin
                if (req) begin
                    nxt = P_RESET;
                    m_retry = 0;
                end else if (!synced) begin
                    nxt = P_RESET;
                    if (m_relock < 65535) m_relock++;
                end
            end
            P_FAULT: begin
                if (req) begin
                    nxt = P_RESET;
                    m_retry = 0;
                end
            end
            default: nxt = P_RESET;
        endcase
        if (nxt != m_ph) m_entry = m_cyc + 1;
        m_ph = nxt;
        m_cyc++;
    endfunction

    function automatic logic [7:0] model_out();
        return pk((m_ph == P_RESET) || (m_ph == P_FAULT), m_ph == P_RUN,
                  m_ph == P_RUN, m_ph == P_FAULT, m_retry);
    endfunction

    task automatic tick();
        model_step(pll_locked, relock_req);
        @(posedge clk_74a);
        #1;
    endtask

    task automatic applyStimulus(input bit lock, input bit relock, input int n);
        pll_locked = lock;
        relock_req = relock;
        tick();
        relock_req = 1'b0;
        for (int i = 1; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {pll_rst, core_reset_n, ready, fault, retry_count};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got {rst,core,rdy,flt,retry}=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset(input bit lock);
        reset_n    = 1'b0;
        relock_req = 1'b0;
        pll_locked = lock;
        repeat (2) @(posedge clk_74a);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();

        vecs[0]  = '{1'b0, 1'b0, 3, pk(1,0,0,0,0), "pulse_high"};
        vecs[1]  = '{1'b0, 1'b0, 1, pk(0,0,0,0,0), "pulse_end"};
        vecs[2]  = '{1'b0, 1'b0, 9, pk(0,0,0,0,0), "wait_no_lock"};
        vecs[3]  = '{1'b1, 1'b0, 2, pk(0,0,0,0,0), "sync_latency"};
        vecs[4]  = '{1'b1, 1'b0, 1, pk(0,0,0,0,0), "stable_entry"};
        vecs[5]  = '{1'b1, 1'b0, 7, pk(0,0,0,0,0), "stable_hold"};
        vecs[6]  = '{1'b1, 1'b0, 1, pk(0,1,1,0,0), "release"};
        vecs[7]  = '{1'b0, 1'b0, 2, pk(0,1,1,0,0), "loss_in_sync"};
        vecs[8]  = '{1'b0, 1'b0, 1, pk(1,0,0,0,0), "loss_reset"};
        vecs[9]  = '{1'b1, 1'b0, 3, pk(1,0,0,0,0), "relock_pulse"};
        vecs[10] = '{1'b1, 1'b0, 1, pk(0,0,0,0,0), "relock_wait"};
        vecs[11] = '{1'b1, 1'b0, 8, pk(0,0,0,0,0), "restable_hold"};
        vecs[12] = '{1'b1, 1'b0, 1, pk(0,1,1,0,0), "rerun"};

        // reset values while reset_n is held low
        repeat (2) @(posedge clk_74a);
        #1;
        checkOutput("reset_values", pk(1,0,0,0,0));
`ifdef PLL_SUP_STATUS_EN
        checkValue("reset_relock_count", int'(relock_count), 0);
`endif

        // normal bring-up, lock loss in RUN and full recovery
        do_reset(1'b0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].lock, vecs[i].relock, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].exp);
        end
`ifdef PLL_SUP_STATUS_EN
        checkValue("loss_relock_count", int'(relock_count), 1);
`endif

        // glitchy lock: 5 high, 1 low, then high
        do_reset(1'b0);
        applyStimulus(1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("glitch_no_early_release", pk(0,0,0,0,0));
        applyStimulus(1'b1, 1'b0, 5);
        checkOutput("glitch_restable", pk(0,0,0,0,0));
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("glitch_run", pk(0,1,1,0,0));

        // timeouts into FAULT, then relock_req out of FAULT
        do_reset(1'b0);
        applyStimulus(1'b0, 1'b0, 35);
        checkOutput("to_before_first", pk(0,0,0,0,0));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to_retry1", pk(1,0,0,0,1));
        applyStimulus(1'b0, 1'b0, 3);
        checkOutput("to_pulse2_hold", pk(1,0,0,0,1));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to_pulse2_end", pk(0,0,0,0,1));
        applyStimulus(1'b0, 1'b0, 31);
        checkOutput("to_before_second", pk(0,0,0,0,1));
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("to_fault", pk(1,0,0,1,2));
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("fault_ignores_lock", pk(1,0,0,1,2));
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("fault_relock", pk(1,0,0,0,0));

        // relock_req in the same cycle as synced lock loss
        do_reset(1'b1);
        applyStimulus(1'b1, 1'b0, 13);
        checkOutput("coll_run", pk(0,1,1,0,0));
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("coll_pre", pk(0,1,1,0,0));
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("coll_reset", pk(1,0,0,0,0));
`ifdef PLL_SUP_STATUS_EN
        checkValue("coll_relock_count", int'(relock_count), 0);
`endif

        // asynchronous reset while in STABLE
        do_reset(1'b1);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("stable_before_reset", pk(0,0,0,0,0));
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", pk(1,0,0,0,0));

        // randomized run against the reference model
        do_reset(1'b0);
        for (int c = 0; c < 4000; c++) begin
            bit lk;
            bit rq;
            lk = pll_locked;
            if ($urandom_range(0, 15) == 0) lk = ~lk;
            rq = ($urandom_range(0, 99) == 0);
            applyStimulus(lk, rq, 1);
            checkOutput($sformatf("rand_cyc%0d", c), model_out());
`ifdef PLL_SUP_STATUS_EN
            checkValue($sformatf("rand_relock_cyc%0d", c), int'(relock_count), m_relock);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
